// File: rtl/cdc_fifo_pkg.sv
// Shared constants and pointer-code helpers for the dual-clock FIFO.
// The read-side control and the write-side level logic both use these helpers.
package cdc_fifo_pkg;

  localparam int ADDR_W_DEF = 3;
  localparam int CODE_W     = 32;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b[CODE_W-1] = g[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/cdc_fifo_wr_ctrl_if.sv
// Write-side bundle of the dual-clock FIFO: push handshake, synced read pointer, Gray write pointer, RAM port.
// wr_level is present only when CDC_FIFO_WR_LEVEL_EN is defined.
interface cdc_fifo_wr_ctrl_if
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  localparam int PW = ADDR_W + 1;

  logic              wr_valid;
  logic              wr_ready;
  logic              wr_full;
  logic              wr_overflow;
  logic [PW-1:0]     rd_ptr_gray_sync;
  logic [PW-1:0]     wr_ptr_gray;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
`ifdef CDC_FIFO_WR_LEVEL_EN
  logic [PW-1:0]     wr_level;
`endif

  modport master (
    output wr_valid,
    output rd_ptr_gray_sync,
    input  wr_ready,
    input  wr_full,
    input  wr_overflow,
    input  wr_ptr_gray,
    input  mem_we,
    input  mem_waddr
`ifdef CDC_FIFO_WR_LEVEL_EN
    , input wr_level
`endif
  );

  modport slave (
    input  wr_valid,
    input  rd_ptr_gray_sync,
    output wr_ready,
    output wr_full,
    output wr_overflow,
    output wr_ptr_gray,
    output mem_we,
    output mem_waddr
`ifdef CDC_FIFO_WR_LEVEL_EN
    , output wr_level
`endif
  );

endinterface

// File: rtl/cdc_fifo_gray_ptr.sv
// Binary + registered Gray pointer pair with increment enable; gray_next_o is the Gray value after this edge.
// Shared by the write- and read-side controllers; async active-low reset clears both registers.
module cdc_fifo_gray_ptr
  import cdc_fifo_pkg::*;
#(
  parameter int W = ADDR_W_DEF + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] bin_o,
  output logic [W-1:0] gray_o,
  output logic [W-1:0] gray_next_o
);

  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] gray_q, gray_d;

  always_comb begin
    bin_d  = bin_q + W'(inc_i);
    gray_d = W'(bin2gray(CODE_W'(bin_d)));
  end

  // Gray is registered so the synchronizer in the other domain never sees a decode glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign bin_o       = bin_q;
  assign gray_o      = gray_q;
  assign gray_next_o = gray_d;

endmodule

// File: rtl/cdc_fifo_wr_ctrl.sv
// Dual-clock FIFO write control in one_clk: same-cycle push accept and RAM write, registered full/overflow.
// Full is computed against the read pointer synced into one_clk; CDC_FIFO_WR_LEVEL_EN adds a registered fill level.
module cdc_fifo_wr_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              one_clk,
  input  logic              one_rst_n,
  cdc_fifo_wr_ctrl_if.slave wr_if
);

  localparam int PW = ADDR_W + 1;

  logic          push;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_gray;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] rd_gray_lap;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;

  assign push = wr_if.wr_valid & ~full_q;

  cdc_fifo_gray_ptr #(
    .W (PW)
  ) u_wr_ptr (
    .clk_i       (one_clk),
    .rst_ni      (one_rst_n),
    .inc_i       (push),
    .bin_o       (wr_bin),
    .gray_o      (wr_gray),
    .gray_next_o (wr_gray_next)
  );

  // One full lap ahead of the read pointer in Gray code: top two bits inverted, rest equal.
  assign rd_gray_lap = {~wr_if.rd_ptr_gray_sync[PW-1:PW-2], wr_if.rd_ptr_gray_sync[PW-3:0]};

  always_comb begin
    full_d     = (wr_gray_next == rd_gray_lap);
    overflow_d = overflow_q | (wr_if.wr_valid & full_q);
  end

  always_ff @(posedge one_clk or negedge one_rst_n) begin
    if (!one_rst_n) begin
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_if.wr_ready    = ~full_q;
  assign wr_if.wr_full     = full_q;
  assign wr_if.wr_overflow = overflow_q;
  assign wr_if.wr_ptr_gray = wr_gray;
  assign wr_if.mem_we      = push;
  assign wr_if.mem_waddr   = wr_bin[ADDR_W-1:0];

`ifdef CDC_FIFO_WR_LEVEL_EN
  logic [PW-1:0] level_q, level_d;

  // Stale synced read pointer makes this an overestimate, never an underestimate.
  always_comb begin
    level_d = (wr_bin + PW'(push)) - PW'(gray2bin(CODE_W'(wr_if.rd_ptr_gray_sync)));
  end

  always_ff @(posedge one_clk or negedge one_rst_n) begin
    if (!one_rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign wr_if.wr_level = level_q;
`else
  logic wr_bin_msb_unused;
  assign wr_bin_msb_unused = wr_bin[PW-1];
`endif

endmodule

// File: tb/tb_cdc_fifo_wr_ctrl.sv
// Bench for cdc_fifo_wr_ctrl: directed vector table, hand sequences for wrap/reset, and a randomized run
// against a pointer-count model; wr_level is checked when CDC_FIFO_WR_LEVEL_EN is defined.
module tb_cdc_fifo_wr_ctrl;

  localparam int ADDR_W = 3;
  localparam int PW     = ADDR_W + 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PMOD   = 1 << PW;
  localparam int NV     = 12;

  logic one_clk   = 1'b0;
  logic one_rst_n = 1'b0;
  int   checks    = 0;
  int   errors    = 0;

  cdc_fifo_wr_ctrl_if #(.ADDR_W(ADDR_W)) wr_if ();

  cdc_fifo_wr_ctrl #(.ADDR_W(ADDR_W)) dut (
    .one_clk   (one_clk),
    .one_rst_n (one_rst_n),
    .wr_if     (wr_if)
  );

  always #5 one_clk = ~one_clk;

  typedef struct {
    logic          valid;
    int            rd_bin;
    logic          exp_ready;
    logic          exp_we;
    int            exp_waddr;
    logic [PW-1:0] exp_gray;
    logic          exp_full;
    logic          exp_ovf;
    int            exp_level;
  } vec_t;

  vec_t vt[NV];

  // Model: write count and occupancy as plain integers modulo the pointer range.
  int   m_wptr;
  logic m_full;
  logic m_ovf;
  int   m_level;

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] x;
    x = PW'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic mstep(input logic v, input int rd, input string tag);
    logic acc;
    @(negedge one_clk);
    wr_if.wr_valid         = v;
    wr_if.rd_ptr_gray_sync = to_gray(rd);
    acc = v && !m_full;
    #1;
    chk({tag, "/ready"}, 32'(wr_if.wr_ready), 32'(!m_full));
    chk({tag, "/mem_we"}, 32'(wr_if.mem_we), 32'(acc));
    chk({tag, "/mem_waddr"}, 32'(wr_if.mem_waddr), 32'(m_wptr % DEPTH));
    @(posedge one_clk);
    #1;
    if (v && m_full) m_ovf = 1'b1;
    m_wptr  = (m_wptr + (acc ? 1 : 0)) % PMOD;
    m_level = (m_wptr - rd + PMOD) % PMOD;
    m_full  = (m_level == DEPTH);
    chk({tag, "/gray"}, 32'(wr_if.wr_ptr_gray), 32'(to_gray(m_wptr)));
    chk({tag, "/full"}, 32'(wr_if.wr_full), 32'(m_full));
    chk({tag, "/overflow"}, 32'(wr_if.wr_overflow), 32'(m_ovf));
`ifdef CDC_FIFO_WR_LEVEL_EN
    chk({tag, "/level"}, 32'(wr_if.wr_level), 32'(m_level));
`endif
  endtask

  task automatic do_reset(input string tag);
    @(negedge one_clk);
    #2;
    wr_if.wr_valid = 1'b0;
    one_rst_n      = 1'b0;
    #1;
    chk({tag, "/rst_gray"}, 32'(wr_if.wr_ptr_gray), 32'd0);
    chk({tag, "/rst_full"}, 32'(wr_if.wr_full), 32'd0);
    chk({tag, "/rst_ready"}, 32'(wr_if.wr_ready), 32'd1);
    chk({tag, "/rst_ovf"}, 32'(wr_if.wr_overflow), 32'd0);
    chk({tag, "/rst_we"}, 32'(wr_if.mem_we), 32'd0);
    chk({tag, "/rst_waddr"}, 32'(wr_if.mem_waddr), 32'd0);
`ifdef CDC_FIFO_WR_LEVEL_EN
    chk({tag, "/rst_level"}, 32'(wr_if.wr_level), 32'd0);
`endif
    repeat (2) @(posedge one_clk);
    @(negedge one_clk);
    one_rst_n = 1'b1;
    m_wptr  = 0;
    m_full  = 1'b0;
    m_ovf   = 1'b0;
    m_level = 0;
  endtask

  a_gray_step: assert property (@(posedge one_clk) disable iff (!one_rst_n)
      (wr_if.wr_ptr_gray != $past(wr_if.wr_ptr_gray)) |->
      ($countones(wr_if.wr_ptr_gray ^ $past(wr_if.wr_ptr_gray)) == 1))
    else begin
      errors++;
      $display("FAIL gray_hamming actual=%b previous=%b", wr_if.wr_ptr_gray, $past(wr_if.wr_ptr_gray));
    end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] prev_gray;
    int            wraps;
    int            rtrue, rs1, rs2;
    logic          v;

    vt[0]  = '{1'b1, 0, 1'b1, 1'b1, 0, 4'b0001, 1'b0, 1'b0, 1};
    vt[1]  = '{1'b1, 0, 1'b1, 1'b1, 1, 4'b0011, 1'b0, 1'b0, 2};
    vt[2]  = '{1'b1, 0, 1'b1, 1'b1, 2, 4'b0010, 1'b0, 1'b0, 3};
    vt[3]  = '{1'b1, 0, 1'b1, 1'b1, 3, 4'b0110, 1'b0, 1'b0, 4};
    vt[4]  = '{1'b1, 0, 1'b1, 1'b1, 4, 4'b0111, 1'b0, 1'b0, 5};
    vt[5]  = '{1'b1, 0, 1'b1, 1'b1, 5, 4'b0101, 1'b0, 1'b0, 6};
    vt[6]  = '{1'b1, 0, 1'b1, 1'b1, 6, 4'b0100, 1'b0, 1'b0, 7};
    vt[7]  = '{1'b1, 0, 1'b1, 1'b1, 7, 4'b1100, 1'b1, 1'b0, 8};
    vt[8]  = '{1'b1, 0, 1'b0, 1'b0, 0, 4'b1100, 1'b1, 1'b1, 8};
    vt[9]  = '{1'b0, 1, 1'b0, 1'b0, 0, 4'b1100, 1'b0, 1'b1, 7};
    vt[10] = '{1'b1, 1, 1'b1, 1'b1, 0, 4'b1101, 1'b1, 1'b1, 8};
    vt[11] = '{1'b0, 1, 1'b0, 1'b0, 1, 4'b1101, 1'b1, 1'b1, 8};

    wr_if.wr_valid         = 1'b0;
    wr_if.rd_ptr_gray_sync = '0;
    repeat (2) @(posedge one_clk);
    @(negedge one_clk);
    one_rst_n = 1'b1;
    #1;
    chk("reset/full", 32'(wr_if.wr_full), 32'd0);
    chk("reset/ready", 32'(wr_if.wr_ready), 32'd1);
    chk("reset/gray", 32'(wr_if.wr_ptr_gray), 32'd0);
    chk("reset/mem_we", 32'(wr_if.mem_we), 32'd0);
    chk("reset/overflow", 32'(wr_if.wr_overflow), 32'd0);

    // Fill to full, push while full, release one slot, refill.
    for (int i = 0; i < NV; i++) begin
      @(negedge one_clk);
      wr_if.wr_valid         = vt[i].valid;
      wr_if.rd_ptr_gray_sync = to_gray(vt[i].rd_bin);
      #1;
      chk($sformatf("vec%0d/ready", i), 32'(wr_if.wr_ready), 32'(vt[i].exp_ready));
      chk($sformatf("vec%0d/mem_we", i), 32'(wr_if.mem_we), 32'(vt[i].exp_we));
      chk($sformatf("vec%0d/mem_waddr", i), 32'(wr_if.mem_waddr), 32'(vt[i].exp_waddr));
      @(posedge one_clk);
      #1;
      chk($sformatf("vec%0d/gray", i), 32'(wr_if.wr_ptr_gray), 32'(vt[i].exp_gray));
      chk($sformatf("vec%0d/full", i), 32'(wr_if.wr_full), 32'(vt[i].exp_full));
      chk($sformatf("vec%0d/overflow", i), 32'(wr_if.wr_overflow), 32'(vt[i].exp_ovf));
`ifdef CDC_FIFO_WR_LEVEL_EN
      chk($sformatf("vec%0d/level", i), 32'(wr_if.wr_level), 32'(vt[i].exp_level));
`endif
    end

    // Continuous push with the synced read pointer one cycle behind: two wraps, never full.
    do_reset("wrap");
    prev_gray = '0;
    wraps     = 0;
    for (int i = 0; i < 40; i++) begin
      mstep(1'b1, m_wptr, $sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d/hamming", i), 32'($countones(wr_if.wr_ptr_gray ^ prev_gray)), 32'd1);
      if (prev_gray == 4'b1000 && wr_if.wr_ptr_gray == 4'b0000) wraps++;
      prev_gray = wr_if.wr_ptr_gray;
    end
    chk("wrap/count", 32'(wraps), 32'd2);

    // Mid-stream asynchronous reset with the pointer at 0110.
    do_reset("pre_mid");
    for (int i = 0; i < 4; i++) mstep(1'b1, 0, $sformatf("mid%0d", i));
    chk("mid/gray_before_reset", 32'(wr_if.wr_ptr_gray), 32'(4'b0110));
    do_reset("mid");
    mstep(1'b1, 0, "mid_after");
    chk("mid_after/gray", 32'(wr_if.wr_ptr_gray), 32'(4'b0001));

    // Random pushes against a read side that pops with a two-cycle synchronizer lag.
    do_reset("rand");
    rtrue = 0;
    rs1   = 0;
    rs2   = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (i >= 200 && i < 260) v = 1'b1;
      mstep(v, rs2, $sformatf("rand%0d", i));
      rs2 = rs1;
      rs1 = rtrue;
      if (((m_wptr - rtrue + PMOD) % PMOD) > 0 && $urandom_range(0, 2) == 0)
        rtrue = (rtrue + 1) % PMOD;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
